// File: rtl/btn_mmio_responder_pkg.sv
// Shared definitions for the push-button MMIO responder.
//   BTN_NUM        : number of buttons served (C, U, D, L)
//   BTN_REG_*      : register offsets within the 16-byte window
//   BtnVec         : one bit per button
package btn_mmio_responder_pkg;
  localparam int BTN_NUM = 4;

  localparam logic [3:0] BTN_REG_STATUS   = 4'h0;
  localparam logic [3:0] BTN_REG_EVENT    = 4'h4;
  localparam logic [3:0] BTN_REG_EVCLR    = 4'h8;
  localparam logic [3:0] BTN_REG_PRESSCNT = 4'hC;

  typedef logic [BTN_NUM-1:0] BtnVec;
endpackage

// File: rtl/btn_debouncer.sv
// One button: 2-flop synchronizer followed by a counting debouncer.
// Ports:
//   clk, rst : clock, synchronous active-low reset
//   rawIn    : raw asynchronous button level
//   level    : debounced level
//   rise     : one-cycle pulse, high in the cycle the debounced level goes 0->1
//              (so the event lands on the same edge as the level change)
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_WIDTH       = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic rawIn,
  output logic level,
  output logic rise
);
  logic                 meta;
  logic                 sync;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 done;

  // The level flips on the edge where the mismatch has been seen DEBOUNCE_CYCLES times.
  assign done = (sync != level) && (cnt == CNT_WIDTH'(DEBOUNCE_CYCLES - 1));
  assign rise = done & sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      meta <= rawIn;
      sync <= meta;
      if (sync == level) begin
        cnt <= '0;
      end else if (done) begin
        level <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/btn_mmio_responder.sv
// Memory-mapped push-button responder on the CPU data bus.
// Window (BASE_ADDR + offset): 0x0 STATUS (RO debounced levels), 0x4 EVENT
// (latched presses, read clears), 0x8 EVCLR (W1C of EVENT, reads 0),
// 0xC PRESSCNT (btnC presses, saturating at 255, any write loads wdata[7:0]).
// Ports:
//   clk, rst   : clock, synchronous active-low reset
//   btnIn[3:0] : raw buttons, bit0=C bit1=U bit2=D bit3=L
//   addr/wdata : bus address / store data
//   we, re     : store / load strobes, qualified by hit
//   rdata      : combinational read data, 0 on a miss
//   hit        : address falls in the window
//   evPending  : OR of EVENT bits
// Optional macro BTN_AUTOREPEAT_EN: held buttons re-set their EVENT bit every
// REPEAT_CYCLES cycles (without touching PRESSCNT).
module btn_mmio_responder
  import btn_mmio_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0100,
  parameter int          DEBOUNCE_CYCLES = 20000,
  parameter int          CNT_WIDTH       = 15,
  parameter int          REPEAT_CYCLES   = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btnIn,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        evPending
);
  BtnVec      level, rise, evReg, evSet, evClr;
  logic [7:0] pressCnt;
  logic [3:0] off;
  logic       rdEvent, wrEvClr, wrCnt;
  logic       unusedBits;

  assign unusedBits = ^{wdata[31:8], addr[1:0]};

  for (genvar i = 0; i < BTN_NUM; i++) begin : gBtn
    btn_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) uDeb (
      .clk  (clk),
      .rst  (rst),
      .rawIn(btnIn[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  assign hit     = (addr[31:4] == BASE_ADDR[31:4]);
  assign off     = {addr[3:2], 2'b00};
  assign rdEvent = re && hit && (off == BTN_REG_EVENT);
  assign wrEvClr = we && hit && (off == BTN_REG_EVCLR);
  assign wrCnt   = we && hit && (off == BTN_REG_PRESSCNT);

`ifdef BTN_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [BTN_NUM-1:0][RW-1:0] rptCnt;
  BtnVec                      rptHit;

  always_comb begin
    rptHit = '0;
    for (int i = 0; i < BTN_NUM; i++)
      rptHit[i] = level[i] && (rptCnt[i] == RW'(REPEAT_CYCLES - 1));
  end

  // Counts only while the button is held; restarts each period.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rptCnt <= '0;
    end else begin
      for (int i = 0; i < BTN_NUM; i++) begin
        if (!level[i] || rptHit[i]) rptCnt[i] <= '0;
        else                        rptCnt[i] <= rptCnt[i] + 1'b1;
      end
    end
  end

  assign evSet = rise | rptHit;
`else
  assign evSet = rise;
`endif

  assign evClr = (rdEvent ? {BTN_NUM{1'b1}} : '0) | (wrEvClr ? wdata[BTN_NUM-1:0] : '0);

  // Set is applied after clear so a press coinciding with a clear is kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      evReg    <= '0;
      pressCnt <= '0;
    end else begin
      evReg <= (evReg & ~evClr) | evSet;
      if (wrCnt)                            pressCnt <= wdata[7:0];
      else if (rise[0] && pressCnt != 8'hFF) pressCnt <= pressCnt + 8'd1;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        BTN_REG_STATUS:   rdata[BTN_NUM-1:0] = level;
        BTN_REG_EVENT:    rdata[BTN_NUM-1:0] = evReg;
        BTN_REG_PRESSCNT: rdata[7:0]         = pressCnt;
        default:          rdata              = '0;
      endcase
    end
  end

  assign evPending = |evReg;
endmodule

// File: tb/tb_btn_mmio_responder.sv
module tb_btn_mmio_responder;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  btnIn;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, hit, evPending;
  int          vecs = 0;
  int          miss = 0;

  btn_mmio_responder #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH      (15),
    .REPEAT_CYCLES  (10)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btnIn    (btnIn),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .re       (re),
    .rdata    (rdata),
    .hit      (hit),
    .evPending(evPending)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Combinational look at a register, no side effects.
  task automatic chkReg(input string tag, input logic [31:0] o, input logic [31:0] exp);
    addr = BASE + o;
    re = 1'b0;
    we = 1'b0;
    #1;
    check(tag, rdata, exp);
  endtask

  // Load lasting one clock edge; rdata checked before the edge.
  task automatic rdCyc(input string tag, input logic [31:0] o, input logic [31:0] exp);
    addr = BASE + o;
    re = 1'b1;
    #1;
    check(tag, rdata, exp);
    tick(1);
    re = 1'b0;
  endtask

  task automatic wrCyc(input logic [31:0] o, input logic [31:0] d);
    addr  = BASE + o;
    wdata = d;
    we    = 1'b1;
    tick(1);
    we = 1'b0;
  endtask

  initial begin
    logic got;
    rst = 1'b0; btnIn = 4'hF; addr = BASE; wdata = '0; we = 1'b0; re = 1'b0;

    // Reset with all buttons held.
    tick(3);
    chkReg("rst_status", 32'h0, 32'h0);
    chkReg("rst_event", 32'h4, 32'h0);
    check("rst_evpending", {31'b0, evPending}, 32'h0);
    check("rst_hit", {31'b0, hit}, 32'h1);
    rst = 1'b1;
    tick(5);
    chkReg("held_status_c5", 32'h0, 32'h0);
    tick(1);
    chkReg("held_status_c6", 32'h0, 32'hF);
    chkReg("held_event_c6", 32'h4, 32'hF);
    check("held_evpending", {31'b0, evPending}, 32'h1);
    rdCyc("held_event_rd", 32'h4, 32'hF);
    btnIn = 4'h0;
    chkReg("event_after_rdclr", 32'h4, 32'h0);
    tick(7);
    chkReg("release_status", 32'h0, 32'h0);

    // Bounce on btnU: 11 toggles two cycles apart, ending at 1.
    for (int i = 0; i < 11; i++) begin
      btnIn[1] = ~btnIn[1];
      if (i < 10) tick(2);
    end
    tick(5);
    chkReg("bounce_c5", 32'h0, 32'h0);
    tick(1);
    chkReg("bounce_c6", 32'h0, 32'h2);
    chkReg("bounce_event", 32'h4, 32'h2);
    rdCyc("bounce_event_rd", 32'h4, 32'h2);
    btnIn = 4'h0;
    tick(7);

    // Read-clear racing a btnU rise.
    btnIn[0] = 1'b1;
    tick(6);
    chkReg("race_pre_event", 32'h4, 32'h1);
    btnIn[0] = 1'b0;
    tick(7);
    btnIn[1] = 1'b1;
    tick(5);
    rdCyc("race_rd", 32'h4, 32'h1);
    chkReg("race_post_event", 32'h4, 32'h2);
    btnIn = 4'h0;
    tick(7);
    rdCyc("race_clr", 32'h4, 32'h2);
    chkReg("presscnt_2", 32'hC, 32'h2);

    // EVCLR write-one-to-clear.
    btnIn = 4'hF;
    tick(6);
    btnIn = 4'h0;
    tick(7);
    chkReg("evclr_pre", 32'h4, 32'hF);
    wrCyc(32'h8, 32'h5);
    chkReg("evclr_post", 32'h4, 32'hA);
    chkReg("evclr_rd0", 32'h8, 32'h0);
    rdCyc("evclr_clr", 32'h4, 32'hA);
    chkReg("presscnt_3", 32'hC, 32'h3);

    // Saturation of PRESSCNT, then load and continue counting.
    for (int i = 0; i < 300; i++) begin
      btnIn[0] = 1'b1;
      tick(7);
      btnIn[0] = 1'b0;
      tick(7);
    end
    chkReg("presscnt_sat", 32'hC, 32'hFF);
    wrCyc(32'hC, 32'h0000_0010);
    chkReg("presscnt_load", 32'hC, 32'h10);
    btnIn[0] = 1'b1;
    tick(7);
    btnIn[0] = 1'b0;
    tick(7);
    chkReg("presscnt_inc", 32'hC, 32'h11);

    // Decode misses must not disturb anything.
    addr = BASE + 32'h14; re = 1'b1; we = 1'b1; wdata = 32'hFFFF_FFFF;
    #1;
    check("miss_hit", {31'b0, hit}, 32'h0);
    check("miss_rdata", rdata, 32'h0);
    tick(1);
    addr = BASE + 32'h18;
    tick(1);
    addr = BASE + 32'h1C; wdata = 32'h0;
    tick(1);
    re = 1'b0; we = 1'b0;
    chkReg("miss_event", 32'h4, 32'h1);
    chkReg("miss_presscnt", 32'hC, 32'h11);
    chkReg("lowbits_ignored", 32'hF, 32'h11);
    check("inwin_hit", {31'b0, hit}, 32'h1);
    rdCyc("miss_clr", 32'h4, 32'h1);

    // Held btnD: auto-repeat only when the feature is built in.
    btnIn[2] = 1'b1;
    tick(6);
    rdCyc("hold_d_event", 32'h4, 32'h4);
    got = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (evPending) begin
        got = 1'b1;
        break;
      end
    end
`ifdef BTN_AUTOREPEAT_EN
    check("repeat_set", {31'b0, got}, 32'h1);
`else
    check("no_repeat", {31'b0, got}, 32'h0);
`endif
    chkReg("hold_d_presscnt", 32'hC, 32'h11);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
